// File: rtl/midi_cc_bank_tx.sv
// midi_cc_bank_tx: debounced multi-button MIDI Control Change transmitter.
// Each debounced press (and optionally release) queues a CC message that is
// serialised 8N1, LSB first, at CLK_DIV clocks per bit.
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   btn       raw asynchronous active-high buttons
//   midi_tx   serial MIDI out, idle high
//   busy      high while a message is being shifted out
//   msg_sent  one-cycle pulse when a message completes
//   led_act   toggles once per message sent
module midi_cc_bank_tx #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned CLK_DIV         = 3200,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CHANNEL         = 0,
  parameter int unsigned CC_BASE         = 46,
  parameter bit          SEND_RELEASE    = 1'b1,
  parameter bit          RUNNING_STATUS  = 1'b0,
  parameter int unsigned RS_TIMEOUT      = 3_200_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic             midi_tx,
  output logic             busy,
  output logic             msg_sent,
  output logic             led_act
);

  localparam int unsigned BAUD_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RS_W    = $clog2(RS_TIMEOUT + 1);
  localparam int unsigned IDX_W   = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int unsigned FRAME_W = 30;
  localparam int unsigned BITS_W  = 5;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t               r_state, w_state_nxt;
  logic [N_BTN-1:0]     r_sync1, r_sync2, r_db, r_db_d;
  logic [DB_W-1:0]      r_db_cnt [N_BTN];
  logic [N_BTN-1:0]     r_pend, r_val_hi;
  logic [FRAME_W-1:0]   r_shift;
  logic [BITS_W-1:0]    r_bits;
  logic [BAUD_W-1:0]    r_baud;
  logic [RS_W-1:0]      r_idle_cnt;
  logic                 r_rs_valid, r_busy, r_sent, r_led;

  logic [N_BTN-1:0]     w_rise, w_fall, w_evt;
  logic [IDX_W-1:0]     w_sel_idx;
  logic                 w_any, w_capture, w_bit_end, w_frame_end, w_omit;
  logic [6:0]           w_cc, w_val;
  logic [7:0]           w_status;
  logic [FRAME_W-1:0]   w_frame_full, w_frame_short;

  // 2-FF synchroniser and per-button debounce counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      for (int i = 0; i < N_BTN; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int i = 0; i < N_BTN; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Debounced edges become events one cycle after db changes
  assign w_rise = r_db & ~r_db_d;
  assign w_fall = ~r_db & r_db_d & {N_BTN{SEND_RELEASE}};
  assign w_evt  = w_rise | w_fall;

  // Fixed priority: lowest pending index wins
  always_comb begin
    w_sel_idx = '0;
    w_any     = 1'b0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_sel_idx = IDX_W'(i);
        w_any     = 1'b1;
      end
    end
  end

  // Pending flags; a same-cycle event beats the capture clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend   <= '0;
      r_val_hi <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (w_evt[i]) begin
          r_pend[i]   <= 1'b1;
          r_val_hi[i] <= w_rise[i];
        end else if (w_capture && (w_sel_idx == IDX_W'(i))) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  // Frame image: bit 0 goes out first
  assign w_cc          = 7'(CC_BASE) + 7'(w_sel_idx);
  assign w_val         = r_val_hi[w_sel_idx] ? 7'h7F : 7'h00;
  assign w_status      = {4'hB, 4'(CHANNEL)};
  assign w_omit        = RUNNING_STATUS && r_rs_valid;
  assign w_frame_full  = {1'b1, 1'b0, w_val, 1'b0,
                          1'b1, 1'b0, w_cc,  1'b0,
                          1'b1, w_status,    1'b0};
  assign w_frame_short = {10'h3FF, w_frame_full[FRAME_W-1:10]};
  assign w_bit_end     = (r_baud == BAUD_W'(CLK_DIV - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_bit_end && (r_bits == BITS_W'(1))) begin
          w_frame_end = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Shifter, baud timing, status outputs and running-status tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '1;
      r_bits     <= '0;
      r_baud     <= '0;
      r_busy     <= 1'b0;
      r_sent     <= 1'b0;
      r_led      <= 1'b0;
      r_rs_valid <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      r_sent <= w_frame_end;
      r_busy <= (w_state_nxt == ST_SHIFT);
      if (w_frame_end) r_led <= ~r_led;

      if (w_capture) begin
        r_shift <= w_omit ? w_frame_short : w_frame_full;
        r_bits  <= w_omit ? BITS_W'(20) : BITS_W'(30);
        r_baud  <= '0;
      end else if (r_state == ST_SHIFT) begin
        if (w_bit_end) begin
          r_baud <= '0;
          // Final stop bit stays on the line; upper bits are already ones
          if (!w_frame_end) begin
            r_shift <= {1'b1, r_shift[FRAME_W-1:1]};
            r_bits  <= r_bits - BITS_W'(1);
          end else begin
            r_bits <= '0;
          end
        end else begin
          r_baud <= r_baud + BAUD_W'(1);
        end
      end

      if (w_capture && !w_omit)                   r_rs_valid <= 1'b1;
      else if (r_idle_cnt == RS_W'(RS_TIMEOUT))   r_rs_valid <= 1'b0;

      // Idle counter saturates at the timeout
      if ((r_state == ST_IDLE) && !w_any) begin
        if (r_idle_cnt != RS_W'(RS_TIMEOUT)) r_idle_cnt <= r_idle_cnt + RS_W'(1);
      end else begin
        r_idle_cnt <= '0;
      end
    end
  end

  assign midi_tx  = r_shift[0];
  assign busy     = r_busy;
  assign msg_sent = r_sent;
  assign led_act  = r_led;

endmodule

// File: tb/tb_midi_cc_bank_tx.sv
// Testbench for midi_cc_bank_tx: two instances (running status off / on)
// share the buttons; a UART-style monitor decodes each line and compares
// completed messages against a scoreboard filled by the stimulus.
module tb_midi_cc_bank_tx;

  localparam int CLK_DIV = 4;
  localparam int HALF    = CLK_DIV / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       tx0, busy0, sent0, led0;
  logic       tx1, busy1, sent1, led1;
  logic [1:0] w_tx, w_busy, w_sent, w_led;

  assign w_tx   = {tx1, tx0};
  assign w_busy = {busy1, busy0};
  assign w_sent = {sent1, sent0};
  assign w_led  = {led1, led0};

  always #5 clk = ~clk;

  midi_cc_bank_tx #(.N_BTN(4), .CLK_DIV(CLK_DIV), .DEBOUNCE_CYCLES(8), .CHANNEL(0),
                    .CC_BASE(46), .SEND_RELEASE(1'b1), .RUNNING_STATUS(1'b0),
                    .RS_TIMEOUT(50))
  u_dut0 (.clk(clk), .rst(rst), .btn(btn), .midi_tx(tx0), .busy(busy0),
          .msg_sent(sent0), .led_act(led0));

  midi_cc_bank_tx #(.N_BTN(4), .CLK_DIV(CLK_DIV), .DEBOUNCE_CYCLES(8), .CHANNEL(0),
                    .CC_BASE(46), .SEND_RELEASE(1'b1), .RUNNING_STATUS(1'b1),
                    .RS_TIMEOUT(50))
  u_dut1 (.clk(clk), .rst(rst), .btn(btn), .midi_tx(tx1), .busy(busy1),
          .msg_sent(sent1), .led_act(led1));

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard entries: {status present, cc byte, value byte}
  logic [16:0] q0[$];
  logic [16:0] q1[$];
  bit   [3:0]  m_lvl = 4'b0000;
  bit   [1:0]  m_led = 2'b00;
  bit          rs_fresh1 = 1'b1;

  task automatic check(input string name, input int k,
                       input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, k, got, exp);
    end
  endtask

  // Expected message: running-status instance omits status unless the line
  // has been idle long enough since the previous message
  task automatic push_msg(input int i, input bit level);
    logic [7:0] cc;
    logic [7:0] v;
    cc = 8'(46 + i);
    v  = level ? 8'h7F : 8'h00;
    q0.push_back({1'b1, cc, v});
    q1.push_back({rs_fresh1, cc, v});
    rs_fresh1 = 1'b0;
  endtask

  task automatic drive(input bit [3:0] v);
    @(posedge clk);
    #1 btn = v;
  endtask

  // Change the masked buttons with nb bounces of per cycles, then settle
  task automatic change(input bit [3:0] mask, input int nb, input int per);
    bit [3:0] tgt;
    bit [3:0] cur;
    tgt = m_lvl ^ mask;
    cur = m_lvl;
    for (int t = 0; t < nb; t++) begin
      cur = cur ^ mask;
      drive(cur);
      repeat (per - 1) @(posedge clk);
    end
    drive(tgt);
    for (int i = 0; i < 4; i++) if (mask[i]) push_msg(i, tgt[i]);
    m_lvl = tgt;
  endtask

  task automatic drain();
    int quiet;
    int lim;
    quiet = 0;
    lim   = 0;
    while (quiet < 80 && lim < 4000) begin
      @(negedge clk);
      lim++;
      if (!busy0 && !busy1) quiet++;
      else quiet = 0;
    end
    n_cmp++;
    if (quiet < 80) begin
      n_bad++;
      $display("FAIL drain_timeout: got busy after %0d cycles, required idle", lim);
    end
    check("queue_empty", 0, q0.size(), 0);
    check("queue_empty", 1, q1.size(), 0);
    rs_fresh1 = 1'b1;
  endtask

  // which: 0 = busy0 high, 1 = sent1 high
  task automatic wait_sig(input int which, input string name);
    int lim;
    bit hit;
    lim = 0;
    hit = 1'b0;
    while (!hit && lim < 2000) begin
      @(negedge clk);
      lim++;
      hit = (which == 0) ? busy0 : sent1;
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL %s: got no event in %0d cycles, required one", name, lim);
    end
  endtask

  // Two messages with a short idle gap between them
  task automatic scen_gap(input int a, input int b, input int gap);
    change(4'(1 << a), 0, 1);
    wait_sig(1, "wait_first_sent");
    repeat (gap) @(posedge clk);
    change(4'(1 << b), 0, 1);
    drain();
  endtask

  // Button b toggles away and back while a's frame is on the line
  task automatic scen_coalesce(input int a, input int b);
    bit [3:0] bm;
    bm = 4'(1 << b);
    change(4'(1 << a), 0, 1);
    wait_sig(0, "wait_busy");
    repeat (3) @(posedge clk);
    drive(m_lvl ^ bm);
    repeat (13) @(posedge clk);
    drive(m_lvl);
    push_msg(b, m_lvl[b]);
    drain();
  endtask

  task automatic reset_outputs_check(input string name);
    check({name, "_tx"}, 0, tx0, 1);
    check({name, "_tx"}, 1, tx1, 1);
    check({name, "_busy"}, 0, busy0, 0);
    check({name, "_busy"}, 1, busy1, 0);
    check({name, "_sent"}, 0, sent0, 0);
    check({name, "_sent"}, 1, sent1, 0);
    check({name, "_led"}, 0, led0, 0);
    check({name, "_led"}, 1, led1, 0);
  endtask

  // Monitor state
  int         n_s = 0;
  int         d_act[2], d_bit[2], d_c[2], nb[2], busy_cnt[2], last_start[2];
  logic [7:0] d_sh[2];
  logic [7:0] d_byte[2][3];
  bit         prev_sent[2];

  initial begin
    logic [16:0] got;
    logic [16:0] exp;
    bit          have;
    for (int k = 0; k < 2; k++) begin
      d_act[k] = 0; nb[k] = 0; busy_cnt[k] = 0; last_start[k] = -1; prev_sent[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      n_s++;
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          d_act[k] = 0; nb[k] = 0; busy_cnt[k] = 0; last_start[k] = -1;
          prev_sent[k] = 1'b0;
          continue;
        end
        if (w_busy[k]) busy_cnt[k]++;
        if (d_act[k] == 0) begin
          if (w_tx[k] == 1'b0) begin
            d_act[k] = 1; d_bit[k] = 0; d_c[k] = 0;
            if (last_start[k] >= 0) begin
              if (nb[k] != 0)
                check("byte_spacing", k, n_s - last_start[k], 10 * CLK_DIV);
              else if (prev_sent[k])
                check("queued_gap", k, n_s - last_start[k], 10 * CLK_DIV + 1);
            end
            last_start[k] = n_s;
          end
        end else begin
          d_c[k]++;
          if (d_c[k] == CLK_DIV) begin
            d_c[k] = 0;
            d_bit[k]++;
          end
          if (d_c[k] == HALF) begin
            if (d_bit[k] == 0) begin
              check("start_bit", k, w_tx[k], 0);
            end else if (d_bit[k] <= 8) begin
              d_sh[k] = {w_tx[k], d_sh[k][7:1]};
            end else begin
              check("stop_bit", k, w_tx[k], 1);
              if (nb[k] < 3) d_byte[k][nb[k]] = d_sh[k];
              nb[k]++;
              d_act[k] = 0;
            end
          end
        end
        if (w_sent[k]) begin
          check("sent_pulse", k, prev_sent[k], 0);
          if (nb[k] == 3 && d_byte[k][0] == 8'hB0) got = {1'b1, d_byte[k][1], d_byte[k][2]};
          else if (nb[k] == 2)                     got = {1'b0, d_byte[k][0], d_byte[k][1]};
          else                                     got = 17'h1FFFF;
          have = 1'b0;
          exp  = '0;
          if (k == 0) begin
            if (q0.size() > 0) begin have = 1'b1; exp = q0.pop_front(); end
          end else begin
            if (q1.size() > 0) begin have = 1'b1; exp = q1.pop_front(); end
          end
          if (!have) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_msg dut%0d: got 0x%0h expected none", k, got);
          end else begin
            check("message", k, got, exp);
            check("frame_len", k, busy_cnt[k], (exp[16] ? 30 : 20) * CLK_DIV);
          end
          m_led[k] = ~m_led[k];
          check("led_act", k, w_led[k], m_led[k]);
          busy_cnt[k] = 0;
          nb[k] = 0;
        end
        prev_sent[k] = w_sent[k];
      end
    end
  end

  initial begin
    int sc, a, b;
    rst = 1'b1;
    btn = 4'b0000;
    repeat (3) @(posedge clk);
    #2 reset_outputs_check("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Single press and release of btn0
    change(4'b0001, 0, 1);  drain();
    change(4'b0001, 0, 1);  drain();
    // Bouncy press and release of btn1
    change(4'b0010, 10, 3); drain();
    change(4'b0010, 6, 2);  drain();
    // Simultaneous btn3 + btn0
    change(4'b1001, 0, 1);  drain();
    change(4'b1001, 3, 1);  drain();
    // Running-status pair, then coalesced press/release of btn2
    scen_gap(0, 1, 10);
    scen_coalesce(0, 2);

    // Reset mid-frame
    change(4'b0100, 0, 1);
    wait_sig(0, "wait_busy_reset");
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b1;
    btn = 4'b0000;
    m_lvl = 4'b0000;
    m_led = 2'b00;
    q0.delete();
    q1.delete();
    #1 reset_outputs_check("midframe_reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rs_fresh1 = 1'b1;
    drain();

    // Randomised scenarios
    for (int it = 0; it < 14; it++) begin
      sc = $urandom_range(0, 2);
      a  = $urandom_range(0, 3);
      b  = (a + $urandom_range(1, 3)) % 4;
      case (sc)
        0: begin
          change(4'($urandom_range(1, 15)), $urandom_range(0, 8), $urandom_range(1, 3));
          drain();
        end
        1: scen_coalesce(a, b);
        default: scen_gap(a, $urandom_range(0, 3), $urandom_range(3, 25));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900_000;
    n_cmp++;
    n_bad++;
    $display("FAIL global_timeout: got no completion, required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
